// File: rtl/rs_age_multi.sv
// Age-ordered reservation station for the ALU path: captures operands from
// several CDB channels and issues the oldest ready entry relative to the ROB head.
module rs_age_multi #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 4,
    parameter int CDB_NUM = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     need_flush_in,
    input  logic [ROB_W-1:0]         rob_head_in,
    input  logic [CDB_NUM-1:0]       cdb_valid_in,
    input  logic [32*CDB_NUM-1:0]    cdb_value_in,
    input  logic [ROB_W*CDB_NUM-1:0] cdb_rob_id_in,
    input  logic                     dec_valid_in,
    input  logic [OP_W-1:0]          dec_op_in,
    input  logic [31:0]              dec_v1_in,
    input  logic [31:0]              dec_v2_in,
    input  logic                     dec_w1_in,
    input  logic                     dec_w2_in,
    input  logic [ROB_W-1:0]         dec_q1_in,
    input  logic [ROB_W-1:0]         dec_q2_in,
    input  logic [ROB_W-1:0]         dec_rob_id_in,
    output logic                     issue_valid_out,
    input  logic                     issue_ready_in,
    output logic [OP_W-1:0]          issue_op_out,
    output logic [31:0]              issue_opr1_out,
    output logic [31:0]              issue_opr2_out,
    output logic [ROB_W-1:0]         issue_rob_id_out,
    output logic                     full_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [31:0]      v1_q  [DEPTH];
    logic [31:0]      v2_q  [DEPTH];
    logic [ROB_W-1:0] q1_q  [DEPTH];
    logic [ROB_W-1:0] q2_q  [DEPTH];
    logic [ROB_W-1:0] rid_q [DEPTH];
    logic [DEPTH-1:0] w1_q;
    logic [DEPTH-1:0] w2_q;
    logic [DEPTH-1:0] busy_q;
    logic [CNT_W-1:0] count_q;

    logic [DEPTH-1:0] wake1_hit;
    logic [DEPTH-1:0] wake2_hit;
    logic [31:0]      wake1_val [DEPTH];
    logic [31:0]      wake2_val [DEPTH];
    logic             byp1_hit;
    logic             byp2_hit;
    logic [31:0]      byp1_val;
    logic [31:0]      byp2_val;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [ROB_W-1:0] sel_age;
    logic [ROB_W-1:0] age;
    logic [IDX_W-1:0] free_idx;

    logic dispatch;
    logic load;
    logic take;

    // Channels are scanned high to low so the lowest matching channel wins.
    always_comb begin
        wake1_hit = '0;
        wake2_hit = '0;
        byp1_hit  = 1'b0;
        byp2_hit  = 1'b0;
        byp1_val  = '0;
        byp2_val  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1_val[i] = '0;
            wake2_val[i] = '0;
        end
        for (int k = CDB_NUM - 1; k >= 0; k--) begin
            if (cdb_valid_in[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_rob_id_in[k*ROB_W +: ROB_W] == q1_q[i]) begin
                        wake1_hit[i] = 1'b1;
                        wake1_val[i] = cdb_value_in[32*k +: 32];
                    end
                    if (cdb_rob_id_in[k*ROB_W +: ROB_W] == q2_q[i]) begin
                        wake2_hit[i] = 1'b1;
                        wake2_val[i] = cdb_value_in[32*k +: 32];
                    end
                end
                if (cdb_rob_id_in[k*ROB_W +: ROB_W] == dec_q1_in) begin
                    byp1_hit = 1'b1;
                    byp1_val = cdb_value_in[32*k +: 32];
                end
                if (cdb_rob_id_in[k*ROB_W +: ROB_W] == dec_q2_in) begin
                    byp2_hit = 1'b1;
                    byp2_val = cdb_value_in[32*k +: 32];
                end
            end
        end
    end

    // Age is the distance from the ROB head, so wraparound orders correctly.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = rid_q[i] - rob_head_in;
            if (busy_q[i] && !w1_q[i] && !w2_q[i] && (!sel_found || age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age;
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full_out  = (count_q == CNT_W'(DEPTH));
    assign count_out = count_q;
    assign dispatch  = dec_valid_in && !full_out;
    assign load      = !issue_valid_out || issue_ready_in;
    assign take      = load && sel_found;

    // The dispatch target is never busy, so it cannot collide with the issued or woken entries.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q           <= '0;
            w1_q             <= '0;
            w2_q             <= '0;
            count_q          <= '0;
            issue_valid_out  <= 1'b0;
            issue_op_out     <= '0;
            issue_opr1_out   <= '0;
            issue_opr2_out   <= '0;
            issue_rob_id_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                rid_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (need_flush_in) begin
                busy_q          <= '0;
                count_q         <= '0;
                issue_valid_out <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i] && w1_q[i] && wake1_hit[i]) begin
                        v1_q[i] <= wake1_val[i];
                        w1_q[i] <= 1'b0;
                    end
                    if (busy_q[i] && w2_q[i] && wake2_hit[i]) begin
                        v2_q[i] <= wake2_val[i];
                        w2_q[i] <= 1'b0;
                    end
                end
                if (take) begin
                    busy_q[sel_idx] <= 1'b0;
                end
                if (dispatch) begin
                    op_q[free_idx]   <= dec_op_in;
                    v1_q[free_idx]   <= (dec_w1_in && byp1_hit) ? byp1_val : dec_v1_in;
                    v2_q[free_idx]   <= (dec_w2_in && byp2_hit) ? byp2_val : dec_v2_in;
                    w1_q[free_idx]   <= dec_w1_in && !byp1_hit;
                    w2_q[free_idx]   <= dec_w2_in && !byp2_hit;
                    q1_q[free_idx]   <= dec_q1_in;
                    q2_q[free_idx]   <= dec_q2_in;
                    rid_q[free_idx]  <= dec_rob_id_in;
                    busy_q[free_idx] <= 1'b1;
                end
                if (load) begin
                    issue_valid_out <= sel_found;
                    if (sel_found) begin
                        issue_op_out     <= op_q[sel_idx];
                        issue_opr1_out   <= v1_q[sel_idx];
                        issue_opr2_out   <= v2_q[sel_idx];
                        issue_rob_id_out <= rid_q[sel_idx];
                    end
                end
                count_q <= count_q + CNT_W'(dispatch) - CNT_W'(take);
            end
        end
    end

endmodule

// File: tb/tb_rs_age_multi.sv
// Directed bench for rs_age_multi: a scoreboard holds each expected issue
// payload and is checked whenever the DUT loads a new one into its issue slot.
module tb_rs_age_multi;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        need_flush_in;
    logic [3:0]  rob_head_in;
    logic [1:0]  cdb_valid_in;
    logic [63:0] cdb_value_in;
    logic [7:0]  cdb_rob_id_in;
    logic        dec_valid_in;
    logic [3:0]  dec_op_in;
    logic [31:0] dec_v1_in;
    logic [31:0] dec_v2_in;
    logic        dec_w1_in;
    logic        dec_w2_in;
    logic [3:0]  dec_q1_in;
    logic [3:0]  dec_q2_in;
    logic [3:0]  dec_rob_id_in;
    logic        issue_valid_out;
    logic        issue_ready_in;
    logic [3:0]  issue_op_out;
    logic [31:0] issue_opr1_out;
    logic [31:0] issue_opr2_out;
    logic [3:0]  issue_rob_id_out;
    logic        full_out;
    logic [3:0]  count_out;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [3:0]  rid;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    rs_age_multi #(.DEPTH(8), .ROB_W(4), .OP_W(4), .CDB_NUM(2)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rdy_in          (rdy_in),
        .need_flush_in   (need_flush_in),
        .rob_head_in     (rob_head_in),
        .cdb_valid_in    (cdb_valid_in),
        .cdb_value_in    (cdb_value_in),
        .cdb_rob_id_in   (cdb_rob_id_in),
        .dec_valid_in    (dec_valid_in),
        .dec_op_in       (dec_op_in),
        .dec_v1_in       (dec_v1_in),
        .dec_v2_in       (dec_v2_in),
        .dec_w1_in       (dec_w1_in),
        .dec_w2_in       (dec_w2_in),
        .dec_q1_in       (dec_q1_in),
        .dec_q2_in       (dec_q2_in),
        .dec_rob_id_in   (dec_rob_id_in),
        .issue_valid_out (issue_valid_out),
        .issue_ready_in  (issue_ready_in),
        .issue_op_out    (issue_op_out),
        .issue_opr1_out  (issue_opr1_out),
        .issue_opr2_out  (issue_opr2_out),
        .issue_rob_id_out(issue_rob_id_out),
        .full_out        (full_out),
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; a newly loaded issue payload is compared against the scoreboard head.
    task automatic applyStimulus();
        logic load_pending;
        exp_t e;
        load_pending = rst_n_in && rdy_in && !need_flush_in && (!issue_valid_out || issue_ready_in);
        @(posedge clk_in);
        #1;
        if (load_pending && issue_valid_out) begin
            checkOutput("sb_expected_issue", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("sb_op",   32'(issue_op_out),     32'(e.op));
                checkOutput("sb_opr1", issue_opr1_out,        e.opr1);
                checkOutput("sb_opr2", issue_opr2_out,        e.opr2);
                checkOutput("sb_rid",  32'(issue_rob_id_out), 32'(e.rid));
            end
        end
    endtask

    task automatic setDispatch(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                               input logic w1, input logic w2, input logic [3:0] q1,
                               input logic [3:0] q2, input logic [3:0] rid);
        dec_valid_in  = 1'b1;
        dec_op_in     = op;
        dec_v1_in     = v1;
        dec_v2_in     = v2;
        dec_w1_in     = w1;
        dec_w2_in     = w2;
        dec_q1_in     = q1;
        dec_q2_in     = q2;
        dec_rob_id_in = rid;
    endtask

    task automatic pushExpect(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rid);
        exp_t e;
        e.op = op; e.opr1 = a; e.opr2 = b; e.rid = rid;
        sb.push_back(e);
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; need_flush_in = 1'b0; rob_head_in = 4'd0;
        cdb_valid_in = '0; cdb_value_in = '0; cdb_rob_id_in = '0;
        dec_valid_in = 1'b0; dec_op_in = '0; dec_v1_in = '0; dec_v2_in = '0;
        dec_w1_in = 1'b0; dec_w2_in = 1'b0; dec_q1_in = '0; dec_q2_in = '0; dec_rob_id_in = '0;
        issue_ready_in = 1'b1;
        applyStimulus();
        applyStimulus();
        rst_n_in = 1'b1;
        checkOutput("rst_valid", 32'(issue_valid_out), 32'd0);
        checkOutput("rst_count", 32'(count_out), 32'd0);
        checkOutput("rst_full", 32'(full_out), 32'd0);
        checkOutput("rst_opr1", issue_opr1_out, 32'd0);

        // Asynchronous reset while an issue is pending and entries are occupied.
        issue_ready_in = 1'b0;
        setDispatch(4'd1, 32'h0, 32'h11, 1'b1, 1'b0, 4'd9, 4'd0, 4'd1);
        applyStimulus();
        setDispatch(4'd2, 32'h0, 32'h22, 1'b1, 1'b0, 4'd9, 4'd0, 4'd2);
        applyStimulus();
        setDispatch(4'd3, 32'h33, 32'h34, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
        pushExpect(4'd3, 32'h33, 32'h34, 4'd3);
        applyStimulus();
        dec_valid_in = 1'b0;
        checkOutput("pre_rst_count3", 32'(count_out), 32'd3);
        applyStimulus();
        checkOutput("pre_rst_valid", 32'(issue_valid_out), 32'd1);
        checkOutput("pre_rst_count2", 32'(count_out), 32'd2);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(issue_valid_out), 32'd0);
        checkOutput("async_rst_count", 32'(count_out), 32'd0);
        applyStimulus();
        rst_n_in = 1'b1;
        issue_ready_in = 1'b1;

        // Back-to-back ready dispatch.
        rob_head_in = 4'd5;
        setDispatch(4'd1, 32'd11, 32'd22, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5);
        pushExpect(4'd1, 32'd11, 32'd22, 4'd5);
        applyStimulus();
        checkOutput("b2b_valid_e1", 32'(issue_valid_out), 32'd0);
        setDispatch(4'd2, 32'd33, 32'd44, 1'b0, 1'b0, 4'd0, 4'd0, 4'd6);
        pushExpect(4'd2, 32'd33, 32'd44, 4'd6);
        applyStimulus();
        dec_valid_in = 1'b0;
        checkOutput("b2b_first_valid", 32'(issue_valid_out), 32'd1);
        checkOutput("b2b_first_rid", 32'(issue_rob_id_out), 32'd5);
        checkOutput("b2b_count", 32'(count_out), 32'd1);
        applyStimulus();
        checkOutput("b2b_second_rid", 32'(issue_rob_id_out), 32'd6);
        checkOutput("b2b_drain_count", 32'(count_out), 32'd0);
        applyStimulus();
        checkOutput("b2b_idle_valid", 32'(issue_valid_out), 32'd0);

        // Age wraparound: both entries wake together, rob 15 is older than rob 1 for head 14.
        rob_head_in = 4'd14;
        setDispatch(4'd4, 32'h0, 32'h2, 1'b1, 1'b0, 4'd4, 4'd0, 4'd1);
        applyStimulus();
        setDispatch(4'd5, 32'h0, 32'h15, 1'b1, 1'b0, 4'd4, 4'd0, 4'd15);
        applyStimulus();
        dec_valid_in = 1'b0;
        cdb_valid_in = 2'b01; cdb_rob_id_in = {4'd0, 4'd4}; cdb_value_in = {32'h0, 32'h40};
        pushExpect(4'd5, 32'h40, 32'h15, 4'd15);
        pushExpect(4'd4, 32'h40, 32'h2, 4'd1);
        applyStimulus();
        cdb_valid_in = 2'b00;
        checkOutput("wrap_wake_valid", 32'(issue_valid_out), 32'd0);
        applyStimulus();
        checkOutput("wrap_first_rid", 32'(issue_rob_id_out), 32'd15);
        applyStimulus();
        checkOutput("wrap_second_rid", 32'(issue_rob_id_out), 32'd1);
        applyStimulus();

        // Dual-channel wakeup of both operands in one cycle.
        rob_head_in = 4'd0;
        setDispatch(4'd6, 32'h0, 32'h0, 1'b1, 1'b1, 4'd3, 4'd7, 4'd8);
        applyStimulus();
        dec_valid_in = 1'b0;
        cdb_valid_in = 2'b11; cdb_rob_id_in = {4'd7, 4'd3}; cdb_value_in = {32'h5555, 32'hAAAA};
        pushExpect(4'd6, 32'hAAAA, 32'h5555, 4'd8);
        applyStimulus();
        cdb_valid_in = 2'b00;
        applyStimulus();
        checkOutput("dual_valid", 32'(issue_valid_out), 32'd1);
        checkOutput("dual_opr1", issue_opr1_out, 32'hAAAA);
        checkOutput("dual_opr2", issue_opr2_out, 32'h5555);
        applyStimulus();

        // Dispatch-time bypass from channel 1, then backpressure holds the payload.
        issue_ready_in = 1'b0;
        setDispatch(4'd7, 32'h0, 32'h77, 1'b1, 1'b0, 4'd2, 4'd0, 4'd9);
        cdb_valid_in = 2'b10; cdb_rob_id_in = {4'd2, 4'd0}; cdb_value_in = {32'h1234, 32'h0};
        pushExpect(4'd7, 32'h1234, 32'h77, 4'd9);
        applyStimulus();
        dec_valid_in = 1'b0;
        cdb_valid_in = 2'b00;
        checkOutput("byp_count", 32'(count_out), 32'd1);
        applyStimulus();
        for (int c = 0; c < 3; c++) begin
            checkOutput("bp_valid", 32'(issue_valid_out), 32'd1);
            checkOutput("bp_opr1", issue_opr1_out, 32'h1234);
            checkOutput("bp_count", 32'(count_out), 32'd0);
            applyStimulus();
        end
        issue_ready_in = 1'b1;
        applyStimulus();
        checkOutput("bp_release_valid", 32'(issue_valid_out), 32'd0);

        // Fill with waiting entries, overflow request ignored, then flush beats dispatch.
        for (int r = 0; r < 8; r++) begin
            setDispatch(4'd8, 32'h0, 32'h0, 1'b1, 1'b0, 4'd15, 4'd0, 4'(r));
            applyStimulus();
        end
        checkOutput("full_flag", 32'(full_out), 32'd1);
        checkOutput("full_count", 32'(count_out), 32'd8);
        setDispatch(4'd9, 32'h99, 32'h98, 1'b0, 1'b0, 4'd0, 4'd0, 4'd10);
        applyStimulus();
        checkOutput("overflow_count", 32'(count_out), 32'd8);
        checkOutput("overflow_valid", 32'(issue_valid_out), 32'd0);
        need_flush_in = 1'b1;
        setDispatch(4'd9, 32'h99, 32'h98, 1'b0, 1'b0, 4'd0, 4'd0, 4'd11);
        applyStimulus();
        need_flush_in = 1'b0;
        dec_valid_in = 1'b0;
        checkOutput("flush_count", 32'(count_out), 32'd0);
        checkOutput("flush_full", 32'(full_out), 32'd0);
        checkOutput("flush_valid", 32'(issue_valid_out), 32'd0);
        applyStimulus();
        checkOutput("flush_no_write_valid", 32'(issue_valid_out), 32'd0);
        checkOutput("flush_no_write_count", 32'(count_out), 32'd0);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
